// File: rtl/norm_pkg.sv
// Shared FSM encoding and fixed-point helpers for the per-lane normalization pipeline.
package norm_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_e;

    // Stage widths: S1 difference keeps one guard bit, S2 product holds d * zero-extended inv_var.
    function automatic int unsigned sub_w(input int unsigned dw);
        return dw + 1;
    endfunction

    function automatic int unsigned prod_w(input int unsigned dw);
        return 2 * dw + 1;
    endfunction

    // Round half up at the binary point, then clamp to the dw-bit signed range.
    function automatic logic signed [63:0] round_sat(input logic signed [63:0] p,
                                                     input int unsigned frac,
                                                     input int unsigned dw);
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        r  = (p + (64'sd1 <<< (frac - 1))) >>> frac;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        if (r > hi) begin
            r = hi;
        end else if (r < lo) begin
            r = lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/norm_channelwise_if.sv
// Column-beat stream handshake: upstream beats in, normalized beats out.
interface norm_channelwise_if #(
    parameter int unsigned DESIGN_SIZE = 4,
    parameter int unsigned DWIDTH      = 8
);
    logic                          in_valid;
    logic                          in_ready;
    logic [DESIGN_SIZE*DWIDTH-1:0] inp_data;
    logic                          out_valid;
    logic                          out_ready;
    logic [DESIGN_SIZE*DWIDTH-1:0] out_data;

    modport master (
        output in_valid, inp_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, inp_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/norm_lane.sv
// One lane of the 3-stage normalize datapath; masked-off lanes ride the same stages unchanged.
module norm_lane
    import norm_pkg::*;
#(
    parameter int unsigned DWIDTH    = 8,
    parameter int unsigned FRAC_BITS = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              adv,
    input  logic [2:0]        ld,
    input  logic              mask,
    input  logic [DWIDTH-1:0] x,
    input  logic [DWIDTH-1:0] mean,
    input  logic [DWIDTH-1:0] inv_var,
    output logic [DWIDTH-1:0] r
);
    localparam int unsigned SW = sub_w(DWIDTH);
    localparam int unsigned PW = prod_w(DWIDTH);

    logic [SW-1:0]     s1_q, s1_d;
    logic [PW-1:0]     s2_q, s2_d;
    logic [PW-1:0]     s1_ext, iv_ext;
    logic [DWIDTH-1:0] s3_q, s3_d;

    // Pass-through lanes carry x sign-extended so its low bits survive both wide stages.
    always_comb begin
        s1_d = {x[DWIDTH-1], x};
        if (mask) begin
            s1_d = {x[DWIDTH-1], x} - {mean[DWIDTH-1], mean};
        end
        s1_ext = {{(PW-SW){s1_q[SW-1]}}, s1_q};
        iv_ext = {{(PW-DWIDTH){1'b0}}, inv_var};
        s2_d   = mask ? s1_ext * iv_ext : s1_ext;
        s3_d   = mask ? DWIDTH'(round_sat($signed({{(64-PW){s2_q[PW-1]}}, s2_q}), FRAC_BITS, DWIDTH))
                      : s2_q[DWIDTH-1:0];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else if (adv) begin
            if (ld[0]) s1_q <= s1_d;
            if (ld[1]) s2_q <= s2_d;
            if (ld[2]) s3_q <= s3_d;
        end
    end

    assign r = s3_q;

endmodule

// File: rtl/norm_channelwise.sv
// Per-lane batch-normalization stage: pass FSM, config latches, stage valids and bypass muxing.
module norm_channelwise
    import norm_pkg::*;
#(
    parameter int unsigned DESIGN_SIZE = 4,
    parameter int unsigned DWIDTH      = 8,
    parameter int unsigned FRAC_BITS   = 4,
    parameter int unsigned CNT_WIDTH   = 8
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          enable_norm,
    input  logic                          start,
    input  logic [CNT_WIDTH-1:0]          num_cols,
    input  logic [DESIGN_SIZE*DWIDTH-1:0] mean,
    input  logic [DESIGN_SIZE*DWIDTH-1:0] inv_var,
    input  logic [DESIGN_SIZE-1:0]        validity_mask,
    norm_channelwise_if.slave             bus,
    output logic                          done_norm,
    output logic                          busy
);
    state_e                        state_q, state_d;
    logic [CNT_WIDTH-1:0]          cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]          ncols_q;
    logic [DESIGN_SIZE*DWIDTH-1:0] mean_q, inv_var_q, lane_out;
    logic [DESIGN_SIZE-1:0]        mask_q;
    logic [2:0]                    vld_q, vld_d;
    logic                          adv, run_ready, accept, cfg_load;

    assign adv       = ~vld_q[2] | bus.out_ready;
    assign run_ready = (state_q == S_RUN) && (cnt_q < ncols_q) && adv;
    assign accept    = enable_norm & run_ready & bus.in_valid;
    assign cfg_load  = enable_norm & start & (state_q == S_IDLE);

    always_comb begin
        vld_d = vld_q;
        if (!enable_norm) begin
            vld_d = '0;
        end else if (adv) begin
            vld_d = {vld_q[1:0], accept};
        end
    end

    // DRAIN looks at the post-edge valids so DONE lands right after the final output handshake.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!enable_norm) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_RUN;
                        cnt_d   = '0;
                    end
                end
                S_RUN: begin
                    if (accept) cnt_d = cnt_q + 1'b1;
                    if (cnt_q == ncols_q) state_d = S_DRAIN;
                end
                S_DRAIN: begin
                    if (vld_d == '0) state_d = S_DONE;
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            vld_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ncols_q   <= '0;
            mean_q    <= '0;
            inv_var_q <= '0;
            mask_q    <= '0;
        end else if (cfg_load) begin
            ncols_q   <= num_cols;
            mean_q    <= mean;
            inv_var_q <= inv_var;
            mask_q    <= validity_mask;
        end
    end

    for (genvar g = 0; g < DESIGN_SIZE; g++) begin : g_lane
        norm_lane #(
            .DWIDTH   (DWIDTH),
            .FRAC_BITS(FRAC_BITS)
        ) u_lane (
            .clk    (clk),
            .resetn (resetn),
            .adv    (adv),
            .ld     ({vld_q[1:0], accept}),
            .mask   (mask_q[g]),
            .x      (bus.inp_data[g*DWIDTH +: DWIDTH]),
            .mean   (mean_q[g*DWIDTH +: DWIDTH]),
            .inv_var(inv_var_q[g*DWIDTH +: DWIDTH]),
            .r      (lane_out[g*DWIDTH +: DWIDTH])
        );
    end

    assign bus.out_data  = enable_norm ? lane_out  : bus.inp_data;
    assign bus.out_valid = enable_norm ? vld_q[2]  : bus.in_valid;
    assign bus.in_ready  = enable_norm ? run_ready : bus.out_ready;
    assign done_norm     = enable_norm ? (state_q == S_DONE) : 1'b1;
    assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_norm_channelwise.sv
// Randomized bench for norm_channelwise against an arithmetic reference model and scoreboard.
module tb_norm_channelwise;
    localparam int unsigned DS = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned FB = 4;
    localparam int unsigned CW = 8;
    localparam int MAXV = (1 << (DW - 1)) - 1;
    localparam int MINV = -(1 << (DW - 1));

    typedef struct {
        logic [31:0] d;
        int          cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             resetn;
    logic             enable_norm;
    logic             start;
    logic [CW-1:0]    num_cols;
    logic [DS*DW-1:0] mean;
    logic [DS*DW-1:0] inv_var;
    logic [DS-1:0]    validity_mask;
    logic             done_norm;
    logic             busy;

    norm_channelwise_if #(.DESIGN_SIZE(DS), .DWIDTH(DW)) bus ();

    norm_channelwise #(
        .DESIGN_SIZE(DS),
        .DWIDTH     (DW),
        .FRAC_BITS  (FB),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .enable_norm  (enable_norm),
        .start        (start),
        .num_cols     (num_cols),
        .mean         (mean),
        .inv_var      (inv_var),
        .validity_mask(validity_mask),
        .bus          (bus),
        .done_norm    (done_norm),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          n_acc, n_done, done_cyc, last_out;
    bit          lat_chk;
    logic [31:0] last_data;
    exp_t        sb[$];
    logic [31:0] beats[$];
    int          cm[DS];
    int          civ[DS];
    logic [DS-1:0] cmask;

    task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: saturate(round((x - mean) * inv_var / 2^FB)) per normalized lane, identity otherwise.
    function automatic logic [31:0] model_beat(input logic [31:0] x);
        logic [31:0] res;
        int xv, r;
        res = '0;
        for (int i = 0; i < DS; i++) begin
            xv = int'($signed(x[i*DW +: DW]));
            if (cmask[i]) begin
                r = ((xv - cm[i]) * civ[i] + (1 << (FB - 1))) >>> FB;
                if (r > MAXV) r = MAXV;
                if (r < MINV) r = MINV;
            end else begin
                r = xv;
            end
            res[i*DW +: DW] = r[DW-1:0];
        end
        return res;
    endfunction

    task automatic rand_cfg();
        for (int i = 0; i < DS; i++) begin
            cm[i]  = int'($urandom_range(0, 255)) - 128;
            civ[i] = int'($urandom_range(0, 255));
        end
        cmask = DS'($urandom);
    endtask

    task automatic drive_cfg();
        for (int i = 0; i < DS; i++) begin
            mean[i*DW +: DW]    = cm[i][DW-1:0];
            inv_var[i*DW +: DW] = civ[i][DW-1:0];
        end
        validity_mask = cmask;
    endtask

    // One clock: observe handshakes at the falling edge, then advance past the rising edge.
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (bus.in_valid && bus.in_ready) begin
            sb.push_back('{d: model_beat(bus.inp_data), cyc: cyc});
            n_acc++;
        end
        if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                expect_eq("out_unexpected", bus.out_valid, 1'b0);
            end else begin
                e = sb.pop_front();
                expect_eq("out_data", bus.out_data, e.d);
                if (lat_chk) expect_eq("latency", cyc - e.cyc, 3);
            end
            last_out  = cyc;
            last_data = bus.out_data;
        end
        if (bus.out_valid && !bus.out_ready) expect_eq("stall_in_ready", bus.in_ready, 1'b0);
        if (done_norm) begin
            n_done++;
            done_cyc = cyc;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // vmode 0: in_valid held until n beats taken; rmode 0: ready always, 1: random, 2: 5-cycle stall after first output.
    task automatic run_pass(input int n, input int vmode, input int rmode);
        int hold;
        bit first_seen;
        int st;
        num_cols = CW'(n);
        drive_cfg();
        start         = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        n_acc = 0; n_done = 0; done_cyc = -1; last_out = -1; last_data = '0;
        hold = 0; first_seen = 0;
        lat_chk = (rmode == 0);
        st = cyc;
        step();
        start = 1'b0;
        expect_eq("busy_cycle1", busy, 1'b1);
        if (n > 0) expect_eq("in_ready_cycle1", bus.in_ready, 1'b1);
        for (int t = 0; t < 500 && n_done == 0; t++) begin
            mean          = $urandom;
            inv_var       = $urandom;
            validity_mask = DS'($urandom);
            num_cols      = CW'($urandom);
            start         = ($urandom_range(0, 3) == 0);
            bus.in_valid  = (vmode == 0 && n_acc < n) ? 1'b1 : 1'($urandom_range(0, 1));
            bus.inp_data  = (n_acc < beats.size()) ? beats[n_acc] : $urandom;
            if (rmode == 1) begin
                bus.out_ready = 1'($urandom_range(0, 1));
            end else if (rmode == 2 && hold > 0) begin
                bus.out_ready = 1'b0;
                hold--;
            end else begin
                bus.out_ready = 1'b1;
            end
            step();
            if (rmode == 2 && !first_seen && last_out >= 0) begin
                first_seen = 1;
                hold = 5;
            end
        end
        start         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        expect_eq("done_pulse", n_done, 1);
        if (n > 0) expect_eq("done_after_last_hs", done_cyc - last_out, 1);
        else       expect_eq("done_cycle3", done_cyc - st, 3);
        repeat (3) step();
        expect_eq("done_single", n_done, 1);
        expect_eq("beats_accepted", n_acc, n);
        expect_eq("all_emitted", sb.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        logic        v, rdy;

        resetn = 1'b0; enable_norm = 1'b1; start = 1'b0; num_cols = '0;
        mean = '0; inv_var = '0; validity_mask = '0;
        bus.in_valid = 1'b0; bus.inp_data = '0; bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        expect_eq("rst_out_valid", bus.out_valid, 1'b0);
        expect_eq("rst_in_ready", bus.in_ready, 1'b0);
        expect_eq("rst_done", done_norm, 1'b0);
        expect_eq("rst_busy", busy, 1'b0);
        expect_eq("rst_out_data", bus.out_data, 32'h0);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        expect_eq("idle_busy", busy, 1'b0);
        expect_eq("idle_out_valid", bus.out_valid, 1'b0);

        // Basic: mean 10, unity gain.
        for (int i = 0; i < DS; i++) begin cm[i] = 10; civ[i] = 16; end
        cmask = 4'b1111;
        beats = '{32'h14141414, 32'h1E1E1E1E, 32'h28282828, 32'h32323232};
        run_pass(4, 0, 0);
        expect_eq("basic_last", last_data, 32'h28282828);

        // Rounding and saturation corners, one per lane.
        cm  = '{-128, 127, 0, 0};
        civ = '{32, 127, 8, 8};
        cmask = 4'b1111;
        beats = '{32'hFF01807F};
        run_pass(1, 0, 0);
        expect_eq("round_sat", last_data, 32'h0001807F);

        // Lane mask.
        for (int i = 0; i < DS; i++) begin cm[i] = 1; civ[i] = 32; end
        cmask = 4'b0101;
        beats = '{32'h08070605};
        run_pass(1, 0, 0);
        expect_eq("mask", last_data, 32'h080C0608);

        // Backpressure.
        rand_cfg();
        beats.delete();
        for (int i = 0; i < 6; i++) beats.push_back($urandom);
        run_pass(6, 0, 2);

        // Empty pass.
        rand_cfg();
        beats.delete();
        run_pass(0, 1, 1);

        // Reset in the middle of a pass.
        rand_cfg();
        num_cols = CW'(4);
        drive_cfg();
        start = 1'b1; bus.out_ready = 1'b1; bus.in_valid = 1'b0;
        n_acc = 0; lat_chk = 0;
        step();
        start = 1'b0;
        for (int t = 0; t < 20 && n_acc < 2; t++) begin
            bus.in_valid = 1'b1;
            bus.inp_data = $urandom;
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        step();
        step();
        expect_eq("pre_reset_valid", bus.out_valid, 1'b1);
        #2 resetn = 1'b0;
        #1;
        expect_eq("midrst_out_valid", bus.out_valid, 1'b0);
        expect_eq("midrst_out_data", bus.out_data, 32'h0);
        expect_eq("midrst_busy", busy, 1'b0);
        expect_eq("midrst_in_ready", bus.in_ready, 1'b0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        sb.delete();
        bus.out_ready = 1'b1;
        rand_cfg();
        beats.delete();
        run_pass(5, 1, 1);

        // enable_norm dropped mid-pass: flush, back to idle, no done.
        rand_cfg();
        num_cols = CW'(8);
        drive_cfg();
        start = 1'b1; bus.out_ready = 1'b1; bus.in_valid = 1'b0;
        n_acc = 0; n_done = 0; lat_chk = 1;
        step();
        start = 1'b0;
        repeat (4) begin
            bus.in_valid = 1'b1;
            bus.inp_data = $urandom;
            step();
        end
        expect_eq("abort_busy_before", busy, 1'b1);
        enable_norm  = 1'b0;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        enable_norm = 1'b1;
        #1;
        expect_eq("abort_busy", busy, 1'b0);
        expect_eq("abort_out_valid", bus.out_valid, 1'b0);
        sb.delete();
        repeat (4) step();
        expect_eq("abort_no_done", n_done, 0);

        // Bypass is purely combinational.
        enable_norm = 1'b0;
        for (int t = 0; t < 6; t++) begin
            d   = $urandom;
            v   = 1'($urandom_range(0, 1));
            rdy = 1'($urandom_range(0, 1));
            bus.inp_data  = d;
            bus.in_valid  = v;
            bus.out_ready = rdy;
            #1;
            expect_eq("byp_data", bus.out_data, d);
            expect_eq("byp_valid", bus.out_valid, v);
            expect_eq("byp_ready", bus.in_ready, rdy);
            expect_eq("byp_done", done_norm, 1'b1);
            expect_eq("byp_busy", busy, 1'b0);
            @(posedge clk);
            #1;
        end
        enable_norm   = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Random passes.
        beats.delete();
        for (int p = 0; p < 8; p++) begin
            rand_cfg();
            run_pass(int'($urandom_range(0, 12)), 1, (p % 2 == 0) ? 1 : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
